// File: rtl/parity_frame_checker.sv
// Per-lane framed serial parity checker: tracks running data parity, checks the
// trailing parity bit against even/odd mode, and keeps a saturating error count.
module parity_frame_checker #(
    parameter int CHANNELS  = 4,
    parameter int FRAME_LEN = 8,
    parameter int ERR_CNT_W = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [CHANNELS-1:0]             x,
    input  logic [CHANNELS-1:0]             x_valid,
    input  logic [CHANNELS-1:0]             sof,
    input  logic                            mode,
    input  logic                            clr_cnt,
    output logic [CHANNELS-1:0]             z,
    output logic [CHANNELS-1:0]             frame_done,
    output logic [CHANNELS-1:0]             parity_err,
    output logic [CHANNELS*ERR_CNT_W-1:0]   err_count,
    output logic [2*CHANNELS-1:0]           dbg_state_o
);

    localparam int CNT_W = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DATA = 2'd1;
    localparam logic [1:0] S_PAR  = 2'd2;

    // Handshake: x[i] is consumed exactly on cycles with x_valid[i]=1 (there is
    // no back-pressure); sof[i] only has meaning when x_valid[i]=1.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        logic [1:0]           state_q, state_d;
        logic [CNT_W-1:0]     cnt_q, cnt_d;
        logic                 par_q, par_d;
        logic                 done_q, done_d;
        logic                 perr_q, perr_d;
        logic                 inc;
        logic [ERR_CNT_W-1:0] err_q, err_d;

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            par_d   = par_q;
            done_d  = 1'b0;
            perr_d  = 1'b0;
            inc     = 1'b0;
            if (x_valid[i]) begin
                if (sof[i]) begin
                    // A sof outside IDLE aborts the frame in flight and restarts.
                    inc     = (state_q != S_IDLE);
                    par_d   = x[i];
                    cnt_d   = CNT_W'(1);
                    state_d = (FRAME_LEN == 1) ? S_PAR : S_DATA;
                end else begin
                    case (state_q)
                        S_DATA: begin
                            par_d = par_q ^ x[i];
                            cnt_d = cnt_q + CNT_W'(1);
                            if (cnt_d == LAST) state_d = S_PAR;
                        end
                        S_PAR: begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                            perr_d  = ((par_q ^ x[i]) != mode);
                            inc     = perr_d;
                        end
                        default: ;
                    endcase
                end
            end

            if (clr_cnt)                    err_d = '0;
            else if (inc && (err_q != '1)) err_d = err_q + ERR_CNT_W'(1);
            else                            err_d = err_q;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= S_IDLE;
                cnt_q   <= '0;
                par_q   <= 1'b0;
                done_q  <= 1'b0;
                perr_q  <= 1'b0;
                err_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                par_q   <= par_d;
                done_q  <= done_d;
                perr_q  <= perr_d;
                err_q   <= err_d;
            end
        end

        assign z[i]                             = par_q;
        assign frame_done[i]                    = done_q;
        assign parity_err[i]                    = perr_q;
        assign err_count[i*ERR_CNT_W +: ERR_CNT_W] = err_q;
        assign dbg_state_o[2*i +: 2]            = state_q;
    end

endmodule

// File: tb/tb_parity_frame_checker.sv
// Directed plus randomized bench for parity_frame_checker against a frame-level
// reference model that counts ones per lane.
module tb_parity_frame_checker;

    localparam int CH  = 4;
    localparam int FL  = 8;
    localparam int EW  = 2;
    localparam int MAXC = (1 << EW) - 1;

    logic              clk;
    logic              rst_n;
    logic [CH-1:0]     x, x_valid, sof;
    logic              mode, clr_cnt;
    logic [CH-1:0]     z, frame_done, parity_err;
    logic [CH*EW-1:0]  err_count;
    logic [2*CH-1:0]   dbg_state;

    int total = 0;
    int bad   = 0;

    // reference model state
    bit active [CH];
    int nbits  [CH];
    int ones   [CH];
    int errs   [CH];
    bit e_done [CH];
    bit e_perr [CH];

    parity_frame_checker #(.CHANNELS(CH), .FRAME_LEN(FL), .ERR_CNT_W(EW)) dut (
        .clk(clk), .rst_n(rst_n), .x(x), .x_valid(x_valid), .sof(sof),
        .mode(mode), .clr_cnt(clr_cnt), .z(z), .frame_done(frame_done),
        .parity_err(parity_err), .err_count(err_count), .dbg_state_o(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            active[i] = 0; nbits[i] = 0; ones[i] = 0; errs[i] = 0;
            e_done[i] = 0; e_perr[i] = 0;
        end
    endtask

    task automatic model_update(input logic [CH-1:0] xv, vv, sv, input logic m, input logic c);
        for (int i = 0; i < CH; i++) begin
            bit bump;
            bump = 0;
            e_done[i] = 0;
            e_perr[i] = 0;
            if (vv[i]) begin
                if (sv[i]) begin
                    if (active[i]) bump = 1;
                    active[i] = 1;
                    nbits[i]  = 1;
                    ones[i]   = int'(xv[i]);
                end else if (active[i]) begin
                    if (nbits[i] < FL) begin
                        nbits[i]++;
                        ones[i] += int'(xv[i]);
                    end else begin
                        e_done[i] = 1;
                        e_perr[i] = (((ones[i] + int'(xv[i])) % 2) != int'(m));
                        active[i] = 0;
                        bump = e_perr[i];
                    end
                end
            end
            if (c)                         errs[i] = 0;
            else if (bump && errs[i] < MAXC) errs[i]++;
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < CH; i++) begin
            check($sformatf("z[%0d]", i), 32'(z[i]), 32'(ones[i] % 2));
            check($sformatf("frame_done[%0d]", i), 32'(frame_done[i]), 32'(e_done[i]));
            check($sformatf("parity_err[%0d]", i), 32'(parity_err[i]), 32'(e_perr[i]));
            check($sformatf("err_count[%0d]", i), 32'(err_count[i*EW +: EW]), 32'(errs[i]));
        end
    endtask

    // drive one cycle, then compare after the edge
    task automatic step(input logic [CH-1:0] xv, vv, sv, input logic m, input logic c);
        x = xv; x_valid = vv; sof = sv; mode = m; clr_cnt = c;
        @(posedge clk);
        model_update(xv, vv, sv, m, c);
        #1;
        check_all();
    endtask

    task automatic idle(input int n, input logic m);
        for (int k = 0; k < n; k++) step('0, '0, '0, m, 1'b0);
    endtask

    task automatic send_frame(input logic [CH-1:0] lanes, input logic [FL-1:0] d,
                              input logic p, input logic m, input int max_gap,
                              input logic clr_on_p);
        for (int k = 0; k < FL; k++) begin
            idle(int'($urandom_range(max_gap, 0)), m);
            step({CH{d[FL-1-k]}}, lanes, (k == 0) ? lanes : '0, m, 1'b0);
        end
        idle(int'($urandom_range(max_gap, 0)), m);
        step({CH{p}}, lanes, '0, m, clr_on_p);
        idle(1, m);
    endtask

    initial begin
        x = '0; x_valid = '0; sof = '0; mode = 1'b0; clr_cnt = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #12;
        check("reset z", 32'(z), 32'h0);
        check("reset frame_done", 32'(frame_done), 32'h0);
        check("reset err_count", 32'(err_count), 32'h0);
        check("reset state", 32'(dbg_state), 32'h0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: even mode, parity OK on lane 0
        send_frame(4'b0001, 8'b10110010, 1'b0, 1'b0, 0, 1'b0);
        // 2: even mode, parity error on lane 0
        send_frame(4'b0001, 8'b10110010, 1'b1, 1'b0, 0, 1'b0);
        // 3: odd mode, all lanes, gapped
        send_frame(4'b1111, 8'b11100000, 1'b0, 1'b1, 3, 1'b0);
        // 4: abort on lane 1 then a full 0xFF frame
        step(4'b0010, 4'b0010, 4'b0010, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) step({CH{k[0]}}, 4'b0010, '0, 1'b0, 1'b0);
        send_frame(4'b0010, 8'hFF, 1'b0, 1'b0, 1, 1'b0);
        // 5: saturation on lane 2, then clear coinciding with another error
        for (int n = 0; n < 5; n++) send_frame(4'b0100, 8'h00, 1'b1, 1'b0, 0, 1'b0);
        check("sat err_count[2]", 32'(err_count[2*EW +: EW]), 32'(MAXC));
        send_frame(4'b0100, 8'h00, 1'b1, 1'b0, 0, 1'b1);
        check("clr err_count[2]", 32'(err_count[2*EW +: EW]), 32'h0);

        // 6: reset mid-frame, then non-sof bits ignored, then a normal frame
        step(4'b0001, 4'b0001, 4'b0001, 1'b0, 1'b0);
        step(4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b0);
        step(4'b0000, 4'b0001, 4'b0000, 1'b0, 1'b0);
        x = '0; x_valid = '0; sof = '0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("async rst z", 32'(z), 32'h0);
        check("async rst frame_done", 32'(frame_done), 32'h0);
        check("async rst parity_err", 32'(parity_err), 32'h0);
        check("async rst err_count", 32'(err_count), 32'h0);
        check("async rst state", 32'(dbg_state), 32'h0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) step(4'b1111, 4'b1111, '0, 1'b0, 1'b0);
        send_frame(4'b1111, 8'b01100001, 1'b1, 1'b0, 1, 1'b0);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic [CH-1:0] rv, rs, rx;
            rx = CH'($urandom);
            rv = '0;
            rs = '0;
            for (int i = 0; i < CH; i++) begin
                rv[i] = ($urandom_range(1, 0) == 1);
                rs[i] = ($urandom_range(11, 0) == 0);
            end
            step(rx, rv, rs, 1'($urandom), ($urandom_range(49, 0) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/parity_frame_checker.md
Name: parity_frame_checker

Overview:
- Multi-channel successor to the single-bit serial parity detector.
- Each of CHANNELS independent lanes receives framed serial data: a start-of-frame-marked run of FRAME_LEN data bits, then one parity bit.
- Per lane, the block tracks the running data parity, checks the received parity bit against a selectable even/odd mode, and flags errors.
- Per lane, it keeps a saturating error counter. Sits behind a serial receiver front end; results feed status registers.

Parameters:
- CHANNELS, 4: number of independent serial lanes (>=1).
- FRAME_LEN, 8: data bits per frame, excluding the parity bit (>=1).
- ERR_CNT_W, 8: width of each per-lane error counter (>=1).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- x  in  CHANNELS  serial data bit, one per lane.
- x_valid  in  CHANNELS  x[i] is consumed this cycle.
- sof  in  CHANNELS  qualifies x_valid[i]: this bit is the first data bit of a frame.
- mode  in  1  0 = even parity (data+parity has even count of 1s), 1 = odd.
- clr_cnt  in  1  synchronous clear of all error counters.
- z  out  CHANNELS  running parity of data bits of the current/last frame (1 = odd count of 1s).
- frame_done  out  CHANNELS  1-cycle pulse: frame completed normally.
- parity_err  out  CHANNELS  1-cycle pulse, only together with frame_done: parity mismatch.
- err_count  out  CHANNELS*ERR_CNT_W  lane i at bits [i*ERR_CNT_W +: ERR_CNT_W], saturating.

Behaviour:
- Clock is clk. Reset is rst_n: asynchronous, active-low.
- Lanes are fully independent; identical per-lane logic.
- Per-lane state: FSM {IDLE, DATA, PAR}, bit counter of width $clog2(FRAME_LEN+1), parity register.
- Reset (asynchronous, also mid-frame):
  - FSM -> IDLE; bit counter, parity register and all outputs -> 0.
  - err_count -> 0.
- A bit is accepted only when x_valid[i]=1. Cycles with x_valid[i]=0 change nothing; gaps of any length are allowed.
- IDLE:
  - x_valid&sof: parity <= x, cnt <= 1; go to PAR if FRAME_LEN==1, else DATA.
  - x_valid without sof: ignored.
- DATA:
  - x_valid&!sof: parity <= parity^x, cnt <= cnt+1; go to PAR when the new cnt equals FRAME_LEN.
  - x_valid&sof: abort. The frame is discarded, err_count increments, no frame_done, and the bit restarts a new frame as in IDLE.
- PAR:
  - x_valid&!sof: this bit is the parity bit p. Go to IDLE.
  - Next cycle: frame_done[i]=1 and parity_err[i]=((parity^p)!=mode).
  - err_count increments if parity_err.
  - mode is sampled on the cycle p is accepted.
  - x_valid&sof: abort/restart as in DATA.
- z[i] is the registered parity register: 0 after reset, equals x on the first data bit, updates per accepted data bit.
  - z holds its value through PAR and IDLE until the next sof.
  - The parity bit p never affects z.
- Outputs are registered. frame_done and parity_err are high for exactly one cycle, one cycle after the parity bit is accepted.
- A new sof is legal on the cycle frame_done is high, so back-to-back frames need no idle cycle.
- err_count:
  - Increments by 1 per parity error or abort.
  - Saturates at all-ones and never wraps.
  - clr_cnt=1 sets all lanes to 0. If clr_cnt coincides with an increment, the clear wins (result 0).
- mode changes mid-frame affect only frames whose parity bit is accepted after the change.

Test Plan:
1. Parity OK, even mode. Lane0, mode=0: sof with data bits 1,0,1,1,0,0,1,0 (four 1s), then p=0.
   -> frame_done[0] pulses 1 cycle; parity_err[0]=0; z[0]=0; err_count[0]=0.
2. Parity error, even mode. Same data, p=1.
   -> frame_done and parity_err pulse together; err_count[0]=1; other lanes unchanged.
3. Odd mode, all lanes, gapped input. mode=1, all lanes: data 1,1,1,0,0,0,0,0, p=0, with 0-3 random x_valid-low cycles between bits.
   -> every lane frame_done=1, parity_err=0, z=1.
4. Abort mid-frame. Lane1: sof plus 5 data bits, then sof again plus a full 8-bit frame (data 0xFF) with p=0, mode=0.
   -> err_count[1]=1 from the abort; one frame_done with parity_err=0; z[1]=0.
5. Saturation and clear. ERR_CNT_W=2: 5 errored frames.
   -> err_count=3 (saturated). Then clr_cnt in the same cycle as a 6th error -> err_count=0.
6. Reset mid-frame and IDLE filtering. rst_n low after 3 data bits.
   -> all outputs 0 immediately, before the next clock edge.
   - After release, 4 x_valid bits without sof -> ignored, no frame_done.
   - Then a full sof frame -> checked normally.
